// File: rtl/ham_pkg.sv
// Shared types and helpers for the Hamming SECDED decoder pipeline.
// Helpers work on a fixed maximum width; callers pad and pass the live length.
package ham_pkg;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_SEC  = 2'd1,
        ERR_DED  = 2'd2
    } err_t;

    localparam int unsigned MAX_ENC  = 127;
    localparam int unsigned MAX_DATA = 120;

    function automatic int unsigned calc_parity_bits(input int unsigned data_bits);
        return $clog2(data_bits) + 1;
    endfunction

    function automatic int unsigned calc_encoded_word(input int unsigned data_bits);
        return data_bits + calc_parity_bits(data_bits);
    endfunction

    function automatic logic is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    function automatic int unsigned ham_syndrome(input logic [MAX_ENC:1] cw,
                                                 input int unsigned     n);
        int unsigned s;
        s = 0;
        for (int unsigned i = 1; i <= MAX_ENC; i++) begin
            if (i <= n && cw[i]) s = s ^ i;
        end
        return s;
    endfunction

    // Data bits occupy the non-power-of-2 positions, lowest position -> LSB.
    function automatic logic [MAX_DATA-1:0] ham_extract(input logic [MAX_ENC:1] cw,
                                                        input int unsigned     n);
        logic [MAX_DATA-1:0] d;
        int unsigned         k;
        d = '0;
        k = 0;
        for (int unsigned i = 1; i <= MAX_ENC; i++) begin
            if (i <= n && !is_pow2(int'(i)) && k < MAX_DATA) begin
                d[k] = cw[i];
                k    = k + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/ham_dec_lane.sv
// One 2-stage SECDED decode lane with valid/ready flow control.
// Error counters are built only when HAM_ERR_CNT_EN is defined.
module ham_dec_lane
    import ham_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned PARITY_BITS  = calc_parity_bits(DATA_BITS),
    parameter int unsigned ENCODED_WORD = DATA_BITS + PARITY_BITS,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [ENCODED_WORD+1:1] i_cw,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_BITS-1:0]    o_data,
    output err_t                    o_err,
    output logic [PARITY_BITS-1:0]  o_syndrome,
    input  logic                    i_cnt_clr,
    output logic [CNT_W-1:0]        o_sec_cnt,
    output logic [CNT_W-1:0]        o_ded_cnt
);

    logic                   adv1, adv2;
    logic                   s1_valid;
    logic [ENCODED_WORD:1]  s1_cw;
    logic [PARITY_BITS-1:0] s1_syn;
    logic                   s1_par;

    logic [MAX_ENC:1]       pad_in, pad_fix;
    logic [PARITY_BITS-1:0] syn_in;
    logic                   par_in;
    logic [ENCODED_WORD:1]  cw_fix;
    err_t                   err_nx;
    logic [DATA_BITS-1:0]   data_nx;

    assign adv2    = !o_valid || i_ready;
    assign adv1    = !s1_valid || adv2;
    assign o_ready = adv1;

    always_comb begin
        pad_in                 = '0;
        pad_in[ENCODED_WORD:1] = i_cw[ENCODED_WORD:1];
        syn_in                 = PARITY_BITS'(ham_syndrome(pad_in, ENCODED_WORD));
        par_in                 = ^i_cw;
    end

    always_comb begin
        cw_fix = s1_cw;
        err_nx = ERR_NONE;
        if (!s1_par) begin
            if (s1_syn != '0) err_nx = ERR_DED;
        end else if (s1_syn == '0) begin
            err_nx = ERR_SEC;
        end else if (32'(s1_syn) <= ENCODED_WORD) begin
            err_nx         = ERR_SEC;
            cw_fix[s1_syn] = ~cw_fix[s1_syn];
        end else begin
            err_nx = ERR_DED;
        end
        pad_fix                 = '0;
        pad_fix[ENCODED_WORD:1] = cw_fix;
        data_nx                 = DATA_BITS'(ham_extract(pad_fix, ENCODED_WORD));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid   <= 1'b0;
            s1_cw      <= '0;
            s1_syn     <= '0;
            s1_par     <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_err      <= ERR_NONE;
            o_syndrome <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= i_valid;
                s1_cw    <= i_cw[ENCODED_WORD:1];
                s1_syn   <= syn_in;
                s1_par   <= par_in;
            end
            // Output registers only change on advance, so a stalled result holds.
            if (adv2) begin
                o_valid <= s1_valid;
                if (s1_valid) begin
                    o_data     <= data_nx;
                    o_err      <= err_nx;
                    o_syndrome <= s1_syn;
                end
            end
        end
    end

`ifdef HAM_ERR_CNT_EN
    logic xfer_out;
    assign xfer_out = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            o_sec_cnt <= '0;
            o_ded_cnt <= '0;
        end else if (xfer_out) begin
            if (o_err == ERR_SEC && o_sec_cnt != '1) o_sec_cnt <= o_sec_cnt + 1'b1;
            if (o_err == ERR_DED && o_ded_cnt != '1) o_ded_cnt <= o_ded_cnt + 1'b1;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = i_cnt_clr;
    assign o_sec_cnt      = '0;
    assign o_ded_cnt      = '0;
`endif

endmodule

// File: rtl/ham_secded_dec_pipe.sv
// Multi-port pipelined Hamming SECDED decoder: NUM_PORTS independent lanes.
// Define HAM_ERR_CNT_EN to build the per-lane SEC/DED error counters.
module ham_secded_dec_pipe
    import ham_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned PARITY_BITS  = calc_parity_bits(DATA_BITS),
    parameter int unsigned ENCODED_WORD = DATA_BITS + PARITY_BITS,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic [NUM_PORTS-1:0]                    i_valid,
    output logic [NUM_PORTS-1:0]                    o_ready,
    input  logic [NUM_PORTS-1:0][ENCODED_WORD+1:1]  i_cw,
    output logic [NUM_PORTS-1:0]                    o_valid,
    input  logic [NUM_PORTS-1:0]                    i_ready,
    output logic [NUM_PORTS-1:0][DATA_BITS-1:0]     o_data,
    output logic [NUM_PORTS-1:0][1:0]               o_err,
    output logic [NUM_PORTS-1:0][PARITY_BITS-1:0]   o_syndrome,
    input  logic                                    i_cnt_clr,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]         o_sec_cnt,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]         o_ded_cnt
);

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
        err_t lane_err;

        ham_dec_lane #(
            .DATA_BITS    (DATA_BITS),
            .PARITY_BITS  (PARITY_BITS),
            .ENCODED_WORD (ENCODED_WORD),
            .CNT_W        (CNT_W)
        ) u_lane (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_valid    (i_valid[g]),
            .o_ready    (o_ready[g]),
            .i_cw       (i_cw[g]),
            .o_valid    (o_valid[g]),
            .i_ready    (i_ready[g]),
            .o_data     (o_data[g]),
            .o_err      (lane_err),
            .o_syndrome (o_syndrome[g]),
            .i_cnt_clr  (i_cnt_clr),
            .o_sec_cnt  (o_sec_cnt[g]),
            .o_ded_cnt  (o_ded_cnt[g])
        );

        assign o_err[g] = lane_err;
    end

endmodule

// File: tb/tb_ham_secded_dec_pipe.sv
// Directed self-checking bench for ham_secded_dec_pipe (defaults, CNT_W=2).
// Counter expectations follow whether HAM_ERR_CNT_EN is defined.
module tb_ham_secded_dec_pipe;
    import ham_pkg::*;

`ifdef HAM_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        i_valid, o_ready, o_valid, i_ready;
    logic [1:0][39:1]  i_cw;
    logic [1:0][31:0]  o_data;
    logic [1:0][1:0]   o_err;
    logic [1:0][5:0]   o_syndrome;
    logic              i_cnt_clr;
    logic [1:0][1:0]   o_sec_cnt, o_ded_cnt;

    int          nchk = 0;
    int          nerr = 0;
    int          snd, rcv;
    logic [31:0] words [4];
    logic [31:0] exp_q [$];
    logic [39:1] cw;
    logic [31:0] held;

    always #5 clk = ~clk;

    ham_secded_dec_pipe #(.CNT_W(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_cw(i_cw), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_err(o_err), .o_syndrome(o_syndrome), .i_cnt_clr(i_cnt_clr),
        .o_sec_cnt(o_sec_cnt), .o_ded_cnt(o_ded_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent even-parity encoder used only to build stimulus.
    function automatic logic [39:1] enc(input logic [31:0] d);
        logic [39:1] c;
        int unsigned k;
        logic        x;
        c = '0;
        k = 0;
        for (int unsigned i = 1; i <= 38; i++)
            if ((i & (i - 1)) != 0) begin c[i] = d[k]; k++; end
        for (int unsigned p = 1; p <= 32; p = p * 2) begin
            x = 1'b0;
            for (int unsigned i = 1; i <= 38; i++)
                if ((i & p) != 0 && i != p) x = x ^ c[i];
            c[p] = x;
        end
        c[39] = ^c[38:1];
        return c;
    endfunction

    task automatic run_word(input string tag, input logic [39:1] w, input logic [31:0] ed,
                            input logic [1:0] ee, input logic [5:0] es);
        i_cw[0] = w; i_valid[0] = 1'b1;
        check({tag, ".ready"}, o_ready[0], 1'b1);
        @(posedge clk); #1;
        i_valid[0] = 1'b0;
        check({tag, ".lat1"}, o_valid[0], 1'b0);
        @(posedge clk); #1;
        check({tag, ".valid"}, o_valid[0], 1'b1);
        check({tag, ".data"}, o_data[0], ed);
        check({tag, ".err"}, o_err[0], ee);
        check({tag, ".syn"}, o_syndrome[0], es);
        @(posedge clk); #1;
        check({tag, ".drain"}, o_valid[0], 1'b0);
    endtask

    task automatic tick();
        if (i_valid[0] && o_ready[0]) begin exp_q.push_back(words[snd]); snd++; end
        if (o_valid[0] && i_ready[0]) begin
            check("stream.order", o_data[0], (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx);
            rcv++;
        end
        @(posedge clk); #1;
        i_valid[0] = (snd < 4);
        if (snd < 4) i_cw[0] = enc(words[snd]);
    endtask

    initial begin
        words = '{32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'h00000001};
        rst = 1'b1; i_valid = '0; i_ready = '1; i_cw = '0; i_cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", o_valid, 2'b00);
        check("rst.data", o_data, 64'h0);
        check("rst.err", o_err, 4'h0);
        check("rst.syn", o_syndrome, 12'h0);
        check("rst.cnt", {o_sec_cnt, o_ded_cnt}, 8'h0);
        rst = 1'b0;

        run_word("t1", 39'h0, 32'h0, ERR_NONE, 6'd0);
        cw = '0; cw[3] = 1'b1;
        run_word("t2", cw, 32'h0, ERR_SEC, 6'd3);
        check("t2.sec_cnt", o_sec_cnt[0], CNT_EN ? 2'd1 : 2'd0);
        cw = '0; cw[3] = 1'b1; cw[5] = 1'b1;
        run_word("t3", cw, 32'h3, ERR_DED, 6'd6);
        check("t3.ded_cnt", o_ded_cnt[0], CNT_EN ? 2'd1 : 2'd0);
        cw = '0; cw[39] = 1'b1;
        run_word("t4", cw, 32'h0, ERR_SEC, 6'd0);
        cw = enc(32'hDEADBEEF); cw[20] = ~cw[20];
        run_word("sec_data", cw, 32'hDEADBEEF, ERR_SEC, 6'd20);
        cw = '0; cw[32] = 1'b1; cw[16] = 1'b1; cw[1] = 1'b1;
        run_word("ded_hi", cw, 32'h0, ERR_DED, 6'd49);
        check("cnt.sat3", o_sec_cnt[0], CNT_EN ? 2'd3 : 2'd0);

        // Lane 1 alone: lane 0 must stay idle.
        cw = enc(32'h12345678); cw[5] = ~cw[5];
        i_cw[1] = cw; i_valid[1] = 1'b1;
        @(posedge clk); #1; i_valid[1] = 1'b0;
        @(posedge clk); #1;
        check("l1.valid", o_valid, 2'b10);
        check("l1.data", o_data[1], 32'h12345678);
        check("l1.err", o_err[1], ERR_SEC);
        check("l1.syn", o_syndrome[1], 6'd5);
        @(posedge clk); #1;

        i_cnt_clr = 1'b1; @(posedge clk); #1; i_cnt_clr = 1'b0;
        check("clr.cnt", {o_sec_cnt, o_ded_cnt}, 8'h0);

        // Stream with a 3-cycle downstream stall.
        snd = 0; rcv = 0; exp_q.delete();
        i_ready[0] = 1'b0; i_valid[0] = 1'b1; i_cw[0] = enc(words[0]);
        tick(); tick();
        held = o_data[0];
        check("stall.held2", {o_valid[0], 8'(snd)}, {1'b1, 8'd2});
        check("stall.ready", o_ready[0], 1'b0);
        check("stall.data", o_data[0], 32'hDEADBEEF);
        tick();
        check("stall.ready2", o_ready[0], 1'b0);
        check("stall.stable", o_data[0], held);
        i_ready[0] = 1'b1; #1;
        check("release.ready", o_ready[0], 1'b1);
        for (int n = 0; n < 30 && rcv < 4; n++) tick();
        check("stream.count", {8'(snd), 8'(rcv), 8'(exp_q.size())}, {8'd4, 8'd4, 8'd0});
        i_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("stream.nodup", o_valid[0], 1'b0);
        check("stream.cnt", {o_sec_cnt[0], o_ded_cnt[0]}, 4'h0);

        // Five SEC words saturate a 2-bit counter.
        for (int j = 0; j < 5; j++) begin
            cw = enc(words[j % 4]); cw[10] = ~cw[10];
            i_cw[0] = cw; i_valid[0] = 1'b1;
            @(posedge clk); #1;
        end
        i_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6.sat", o_sec_cnt[0], CNT_EN ? 2'd3 : 2'd0);
        check("t6.ded0", o_ded_cnt[0], 2'd0);

        // Clear coinciding with a SEC output handshake wins.
        i_cw[0] = cw; i_valid[0] = 1'b1;
        @(posedge clk); #1; i_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("t6.clrv", o_valid[0], 1'b1);
        i_cnt_clr = 1'b1;
        @(posedge clk); #1; i_cnt_clr = 1'b0;
        check("t6.clr_prio", o_sec_cnt[0], 2'd0);

        // Reset with both stages full.
        i_ready[0] = 1'b0; i_valid[0] = 1'b1; i_cw[0] = enc(32'hA5A5A5A5);
        repeat (2) @(posedge clk);
        #1;
        check("t6.full", {o_valid[0], o_ready[0]}, 2'b10);
        i_valid[0] = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("t6.rst_valid", o_valid, 2'b00);
        check("t6.rst_data", o_data[0], 32'h0);
        rst = 1'b0; i_ready[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6.discard", o_valid, 2'b00);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
